// File: rtl/stream_block_sorter.sv
`default_nettype none
// ============================================================================
// Module      : stream_block_sorter
// Description : Streaming insertion sorter; emits ELEMS-key sorted blocks as
//               LANES-wide words through a double-buffered output stage.
//               Define SBS_DESCEND_EN for descending order (pad all-zeros).
// Revision    : 1.0 - initial release
// ============================================================================
module stream_block_sorter #(
    parameter int SORTW = 32,
    parameter int ELEMS = 16,
    parameter int LANES = 2
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [SORTW-1:0]       DIN,
    input  logic                   ENQ,
    input  logic                   FLUSH,
    output logic                   FULL,
    output logic [LANES*SORTW-1:0] DOUT,
    output logic                   DVALID,
    input  logic                   RDY
);

    localparam int WORDS = ELEMS / LANES;
    localparam int CW    = $clog2(ELEMS) + 1;
    localparam int WIW   = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [CW-1:0]  c_elems = CW'(ELEMS);
    localparam logic [WIW-1:0] c_last  = WIW'(WORDS - 1);
`ifdef SBS_DESCEND_EN
    localparam logic [SORTW-1:0] c_pad = '0;
`else
    localparam logic [SORTW-1:0] c_pad = '1;
`endif

    logic [SORTW-1:0] r_key [ELEMS];
    logic [ELEMS-1:0] r_vld;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic [SORTW-1:0] r_buf [ELEMS];
    logic [WIW-1:0]   r_widx;
    logic             r_busy;

    logic [SORTW-1:0] w_nkey [ELEMS];
    logic [ELEMS-1:0] w_nvld;
    logic [ELEMS-1:0] w_keep;
    logic [CW-1:0]    w_ncount;
    logic             w_acc;
    logic             w_flush;
    logic             w_close;
    logic             w_free;
    logic             w_load;
    logic             w_hold;

    assign w_acc   = ENQ && !r_full;
    assign w_flush = FLUSH && !r_full;

    // A cell keeps its slot unless it must move up to open room for DIN.
    for (genvar i = 0; i < ELEMS; i++) begin : g_cell
`ifdef SBS_DESCEND_EN
        assign w_keep[i] = r_vld[i] && (r_key[i] >= DIN);
`else
        assign w_keep[i] = r_vld[i] && (r_key[i] <= DIN);
`endif
        if (i == 0) begin : g_first
            assign w_nkey[i] = (!w_acc || w_keep[i]) ? r_key[i] : DIN;
            assign w_nvld[i] = w_acc ? 1'b1 : r_vld[i];
        end else begin : g_rest
            assign w_nkey[i] = (!w_acc || w_keep[i]) ? r_key[i] :
                               w_keep[i-1]           ? DIN      : r_key[i-1];
            assign w_nvld[i] = w_acc ? r_vld[i-1] : r_vld[i];
        end
    end

    assign w_ncount = w_acc ? (r_count + CW'(1)) : r_count;
    assign w_close  = (w_acc && (w_ncount == c_elems)) ||
                      (w_flush && (w_ncount != '0));
    assign w_free   = !r_busy || (RDY && (r_widx == c_last));
    // A parked block transfers as soon as the buffer frees up.
    assign w_load   = r_full ? w_free : (w_close && w_free);
    assign w_hold   = !r_full && w_close && !w_free;

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < ELEMS; i++) begin
                r_key[i] <= '0;
                r_buf[i] <= '0;
            end
            r_vld   <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_widx  <= '0;
            r_busy  <= 1'b0;
        end else begin
            for (int i = 0; i < ELEMS; i++) begin
                r_key[i] <= w_nkey[i];
            end

            if (r_busy && RDY) begin
                r_widx <= (r_widx == c_last) ? '0 : (r_widx + WIW'(1));
                if (r_widx == c_last) begin
                    r_busy <= 1'b0;
                end
            end

            if (w_load) begin
                for (int i = 0; i < ELEMS; i++) begin
                    r_buf[i] <= w_nvld[i] ? w_nkey[i] : c_pad;
                end
                r_widx  <= '0;
                r_busy  <= 1'b1;
                r_vld   <= '0;
                r_count <= '0;
                r_full  <= 1'b0;
            end else begin
                r_vld   <= w_nvld;
                r_count <= w_ncount;
                if (w_hold) begin
                    r_full <= 1'b1;
                end
            end
        end
    end

    logic [LANES*SORTW-1:0] w_word [WORDS];

    for (genvar w = 0; w < WORDS; w++) begin : g_word
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            assign w_word[w][l*SORTW +: SORTW] = r_buf[w*LANES + l];
        end
    end

    assign DOUT   = w_word[r_widx];
    assign DVALID = r_busy;
    assign FULL   = r_full;

endmodule
`default_nettype wire

// File: doc/stream_block_sorter.md
# stream_block_sorter

Parametrised streaming block sorter: accepts one SORTW-bit key per cycle, sorts each block of ELEMS keys on the fly in a linear insertion array, and emits the sorted block as ELEMS/LANES packed words of LANES*SORTW bits. It is the next-generation front end of the merge-sort datapath, feeding pre-sorted runs to the merge tree and DRAM writer. Compared with the previous sorter, it adds:
- configurable block length and lane count;
- downstream backpressure;
- explicit partial-block flush;
- a double-buffered output, so input does not stall while a block drains.

## Interface
- SORTW, 32, key width in bits (≥1)
- ELEMS, 16, keys per sorted block (≥2, power of two)
- LANES, 2, keys per output word; must divide ELEMS; WORDS = ELEMS/LANES
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- DIN  in  SORTW  input key
- ENQ  in  1  DIN valid; key accepted when ENQ && !FULL
- FLUSH  in  1  close current partial block; accepted when FLUSH && !FULL
- FULL  out  1  input stall, registered
- DOUT  out  LANES*SORTW  output word; lane 0 in bits [SORTW-1:0]
- DVALID  out  1  DOUT valid
- RDY  in  1  downstream ready; word transferred when DVALID && RDY

## Operation
- Insertion array: ELEMS cells, each holding a key and a valid bit, plus a fill count 0..ELEMS-1.
  - On an accepted key, every valid cell whose key is strictly greater than DIN shifts up one slot, and DIN fills the gap.
  - Equal keys keep arrival order.
  - Cells 0..count-1 are always sorted.
- Block close happens on an edge where either:
  - the accepted key makes count reach ELEMS, or
  - an accepted FLUSH leaves at least one valid cell.
- ENQ and FLUSH in the same cycle: the key is inserted first, then the block closes.
- FLUSH with count 0 and no ENQ is ignored.
- Padding: unfilled slots of a flushed block are emitted as the pad value, all-ones (sorts last).
- Output buffer: holds ELEMS keys plus a word index widx (0..WORDS-1) and a busy flag.
  - DOUT = keys[widx*LANES +: LANES].
  - It is "free" in a cycle if not busy, or if DVALID && RDY && widx==WORDS-1.
- Transfer on close:
  - If the buffer is free on the closing edge, the post-insertion array loads directly into the buffer. widx goes to 0, busy/DVALID go to 1, and the array clears to count 0.
  - Otherwise the closed block stays in the array and FULL goes to 1. The transfer then happens on the first edge where the buffer is free, and FULL returns to 0 on that same edge.
- Drain: each handshake increments widx. A handshake at widx==WORDS-1 with no pending transfer clears busy, so DVALID goes to 0.
- While DVALID && !RDY, DOUT and DVALID are held stable.
- ENQ and FLUSH are ignored while FULL=1; no key is lost or duplicated.
- Reset mid-operation discards all array and buffer contents.

## Timing
- Reset values: FULL=0, DVALID=0, DOUT=0, count=0, widx=0, buffer not busy, all cell valid bits 0.
- Input throughput: one key per cycle, sustained whenever the buffer drains (RDY=1 at least WORDS of every ELEMS cycles).
- Latency: DVALID rises on the cycle immediately after the closing key or FLUSH is accepted, provided the buffer is free.
- Back-to-back blocks: with RDY=1 and ENQ=1 every cycle, the last word of block n and word 0 of block n+1 appear on consecutive cycles with no bubble.
- FULL is registered: it rises the cycle after a close that cannot transfer, and falls the cycle after the transfer edge.
- Insertion compare/shift and the array-to-buffer load complete in a single cycle. No multicycle paths.

## Configuration
- SBS_DESCEND_EN defined:
  - cells shift when their key is strictly less than DIN, so blocks sort descending (word 0 lane 0 = largest key);
  - the pad value is all-zeros.
- SBS_DESCEND_EN undefined: ascending order, pad all-ones. Default.

## Test plan
All scenarios use SORTW=8, ELEMS=8, LANES=2.
- Reset: RST high for 2 cycles during random ENQ/FLUSH -> FULL=0, DVALID=0, DOUT=0x0000 on the first cycle after reset.
- Basic sort: keys 7,3,9,1,8,2,6,4 on consecutive cycles, RDY=1 -> DVALID rises the cycle after key 4 is accepted; DOUT = 0x0201, 0x0403, 0x0706, 0x0908 on 4 consecutive cycles, then DVALID=0.
- Duplicates and extremes: 5,0xFF,5,0,5,0xFF,0,5 -> words 0x0000, 0x0505, 0x0505, 0xFFFF.
- Backpressure: RDY=0, feed 16 keys continuously.
  - FULL rises after the 16th key; DOUT holds word 0 of block 1 unchanged.
  - Set RDY=1: block 1 drains in 4 cycles; block 2 word 0 follows with no bubble; FULL falls on the transfer edge.
- Flush:
  - keys 0x10,0x02,0x30 then FLUSH -> 0x1002, 0xFF30, 0xFFFF, 0xFFFF;
  - FLUSH with count 0 -> no DVALID;
  - ENQ 0x05 with FLUSH in the same cycle on an empty array -> 0xFF05, 0xFFFF, 0xFFFF, 0xFFFF.
- Descending build (SBS_DESCEND_EN) with the basic-sort keys -> 0x0809, 0x0607, 0x0304, 0x0102; flushed slots pad with 0x00.
